parking_timer: RTL and testbench

PARKING_TIMER -- requirements
Module: parking_timer

---
 rtl/parking_timer_if.sv | 31 +++
 rtl/parking_timer.sv | 160 ++++++++++++++++
 tb/tb_parking_timer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/parking_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : parking_timer_if
// Brief    : Coin/tick inputs and MM:SS display outputs of the parking timer.
//            The master drives tick and coins; the slave (timer) drives the
//            display and status flags.
// Revision : 1.0  initial release
// ============================================================================
interface parking_timer_if;
  logic       tick_1hz;
  logic       coin_small;
  logic       coin_large;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       parked;
  logic       expired;

  modport master (
    output tick_1hz, coin_small, coin_large,
    input  digit3, digit2, digit1, digit0, parked, expired
  );

  modport slave (
    input  tick_1hz, coin_small, coin_large,
    output digit3, digit2, digit1, digit0, parked, expired
  );
endinterface

`default_nettype wire

// File: rtl/parking_timer.sv
`default_nettype none
// ============================================================================
// Module   : parking_timer
// Brief    : Coin-operated parking meter. Remaining time is held as four BCD
//            digits MM:SS, counts down on a 1 Hz tick and is topped up by
//            small/large coin events, saturating at 99:59.
//            Optional macro COIN_EDGE_DETECT_EN: coin inputs are treated as
//            levels and only their rising edge counts as an event.
// Revision : 1.0  initial release
// ============================================================================
module parking_timer #(
  parameter int SMALL_MIN = 1,  // minutes per small coin, 1..99
  parameter int LARGE_MIN = 5   // minutes per large coin, 1..99
) (
  input  logic           clk,
  input  logic           rst_n,
  parking_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // 9 bits hold the worst case 99 + 99 + 99 before saturation.
  localparam logic [8:0] SMALL_ADD = 9'(SMALL_MIN);
  localparam logic [8:0] LARGE_ADD = 9'(LARGE_MIN);

  state_t     state_q, state_d;
  logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic       parked_q, parked_d;
  logic       expired_q, expired_d;

  logic       coin_small_ev;
  logic       coin_large_ev;
  logic       coin_ev;
  logic       dec;
  logic       t_zero_d;
  logic       borrow;
  logic [8:0] min_bin;
  logic [8:0] min_add;
  logic [8:0] min_sum;

`ifdef COIN_EDGE_DETECT_EN
  logic coin_small_prev_q;
  logic coin_large_prev_q;

  // Remember last cycle's coin levels so a held level counts only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_small_prev_q <= 1'b0;
      coin_large_prev_q <= 1'b0;
    end else begin
      coin_small_prev_q <= bus.coin_small;
      coin_large_prev_q <= bus.coin_large;
    end
  end

  // Event is asserted in the first cycle the level is high.
  assign coin_small_ev = bus.coin_small & ~coin_small_prev_q;
  assign coin_large_ev = bus.coin_large & ~coin_large_prev_q;
`else
  assign coin_small_ev = bus.coin_small;
  assign coin_large_ev = bus.coin_large;
`endif

  assign coin_ev = coin_small_ev | coin_large_ev;
  assign dec     = bus.tick_1hz & (|{min_tens_q, min_ones_q, sec_tens_q, sec_ones_q});

  // Next time value: BCD decrement of seconds, then minutes handled in binary
  // so borrow, coin addition and saturation are one add and one compare.
  always_comb begin
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    borrow     = 1'b0;
    if (dec) begin
      if (sec_ones_q != 4'd0) begin
        sec_ones_d = sec_ones_q - 4'd1;
      end else begin
        sec_ones_d = 4'd9;
        if (sec_tens_q != 4'd0) begin
          sec_tens_d = sec_tens_q - 4'd1;
        end else begin
          sec_tens_d = 4'd5;
          borrow     = 1'b1;  // only reachable with minutes > 0 since T > 0
        end
      end
    end

    min_bin = ({5'd0, min_tens_q} * 9'd10) + {5'd0, min_ones_q} - {8'd0, borrow};
    min_add = (coin_small_ev ? SMALL_ADD : 9'd0) + (coin_large_ev ? LARGE_ADD : 9'd0);
    min_sum = min_bin + min_add;

    if (min_sum > 9'd99) begin
      min_tens_d = 4'd9;
      min_ones_d = 4'd9;
      sec_tens_d = 4'd5;
      sec_ones_d = 4'd9;
    end else begin
      min_tens_d = 4'(min_sum / 9'd10);
      min_ones_d = 4'(min_sum % 9'd10);
    end
  end

  assign t_zero_d = ~(|{min_tens_d, min_ones_d, sec_tens_d, sec_ones_d});

  // Next state and registered status flags.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (coin_ev) state_d = ACTIVE;
      end
      ACTIVE: begin
        // A decrement landing on zero means T was 00:01; a same-cycle coin
        // keeps the meter running instead.
        if (!coin_ev && dec && t_zero_d) state_d = EXPIRED;
      end
      EXPIRED: begin
        if (coin_ev) state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
    parked_d  = ~t_zero_d;
    expired_d = (state_d == EXPIRED);
  end

  // State, time digits and flags; asynchronous clear discards any same-cycle events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      parked_q   <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      parked_q   <= parked_d;
      expired_q  <= expired_d;
    end
  end

  assign bus.digit3  = min_tens_q;
  assign bus.digit2  = min_ones_q;
  assign bus.digit1  = sec_tens_q;
  assign bus.digit0  = sec_ones_q;
  assign bus.parked  = parked_q;
  assign bus.expired = expired_q;

endmodule

`default_nettype wire

// File: tb/tb_parking_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_timer
// Brief    : Directed and randomized bench for parking_timer. The reference
//            model keeps remaining time as a plain count of seconds.
// Revision : 1.0  initial release
// ============================================================================
module tb_parking_timer;

  localparam int SMALL = 1;
  localparam int LARGE = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  parking_timer_if bus ();

  parking_timer #(.SMALL_MIN(SMALL), .LARGE_MIN(LARGE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: seconds remaining, state 0=idle 1=active 2=expired.
  int m_t;
  int m_st;
  bit m_ps;
  bit m_pl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_vec++;
    if (obs !== expd) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expd);
    end
  endtask

  // Display read as a decimal MMSS number, e.g. 99:59 -> 9959.
  function automatic logic [31:0] dut_time();
    return 32'(bus.digit3) * 1000 + 32'(bus.digit2) * 100 + 32'(bus.digit1) * 10 + 32'(bus.digit0);
  endfunction

  function automatic logic [31:0] mmss(input int secs);
    return 32'((secs / 60) * 100 + (secs % 60));
  endfunction

  task automatic model_reset();
    m_t  = 0;
    m_st = 0;
    m_ps = 1'b0;
    m_pl = 1'b0;
  endtask

  task automatic model_step(input bit tk, input bit cs, input bit cl);
    bit es, el;
    int old, mins, secs;
`ifdef COIN_EDGE_DETECT_EN
    es   = cs && !m_ps;
    el   = cl && !m_pl;
    m_ps = cs;
    m_pl = cl;
`else
    es = cs;
    el = cl;
`endif
    old = m_t;
    if (tk && m_t > 0) m_t = m_t - 1;
    if (es || el) begin
      mins = m_t / 60 + (es ? SMALL : 0) + (el ? LARGE : 0);
      secs = m_t % 60;
      m_t  = (mins > 99) ? (99 * 60 + 59) : (mins * 60 + secs);
      m_st = 1;
    end else if (m_st == 1 && tk && old == 1) begin
      m_st = 2;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_time"},    dut_time(),               mmss(m_t));
    check({tag, "_parked"},  32'(bus.parked),          32'(m_t != 0));
    check({tag, "_expired"}, 32'(bus.expired),         32'(m_st == 2));
    check({tag, "_excl"},    32'(bus.parked & bus.expired), 32'(0));
  endtask

  task automatic step(input bit tk, input bit cs, input bit cl);
    @(negedge clk);
    bus.tick_1hz   = tk;
    bus.coin_small = cs;
    bus.coin_large = cl;
    @(posedge clk);
    model_step(tk, cs, cl);
    #1;
    compare_all("step");
  endtask

  // Asynchronous reset mid-cycle; events presented while it is held are discarded.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("rst_async");
    @(negedge clk);
    bus.tick_1hz   = 1'b1;
    bus.coin_small = 1'b1;
    bus.coin_large = 1'b1;
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    @(negedge clk);
    bus.tick_1hz   = 1'b0;
    bus.coin_small = 1'b0;
    bus.coin_large = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int coin_div;
    bus.tick_1hz   = 1'b0;
    bus.coin_small = 1'b0;
    bus.coin_large = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Small coin from reset, then count down to expiry.
    step(0, 1, 0);
    check("small_coin", dut_time(), 32'd100);
    repeat (60) step(1, 0, 0);
    check("expire_time", dut_time(), 32'd0);
    check("expire_flag", 32'(bus.expired), 32'd1);
    step(1, 0, 0);
    check("tick_at_zero", dut_time(), 32'd0);

    // 10:00 -> 09:59
    do_reset();
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    check("borrow_min", dut_time(), 32'd959);

    // 00:10 -> 00:09
    do_reset();
    step(0, 1, 0);
    repeat (50) step(1, 0, 0);
    check("at_0010", dut_time(), 32'd10);
    step(1, 0, 0);
    check("borrow_sec", dut_time(), 32'd9);

    // 98:30 + large coin saturates
    do_reset();
    repeat (19) begin step(0, 0, 1); step(0, 0, 0); end
    repeat (4)  begin step(0, 1, 0); step(0, 0, 0); end
    repeat (30) step(1, 0, 0);
    check("at_9830", dut_time(), 32'd9830);
    step(0, 0, 1);
    check("saturate", dut_time(), 32'd9959);

    // Both coins in one cycle from 00:00
    do_reset();
    step(0, 1, 1);
    check("both_coins", dut_time(), 32'd600);

    // 00:01 with tick and coin together stays active
    do_reset();
    step(0, 1, 0);
    repeat (59) step(1, 0, 0);
    check("at_0001", dut_time(), 32'd1);
    step(1, 1, 0);
    check("tick_coin_time", dut_time(), 32'd100);
    check("tick_coin_exp", 32'(bus.expired), 32'd0);

`ifdef COIN_EDGE_DETECT_EN
    // Level held for 10 cycles counts once.
    do_reset();
    repeat (10) step(0, 1, 0);
    check("held_level", dut_time(), 32'd100);
    step(1, 1, 0);
    do_reset();
    check("reset_after_hold", dut_time(), 32'd0);
`endif

    // Randomized traffic: alternate between coin-heavy and coin-sparse phases
    // so both saturation and expiry are exercised.
    for (int blk = 0; blk < 8; blk++) begin
      coin_div = (blk % 2 == 0) ? 6 : 600;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(999) == 0) begin
          do_reset();
        end else begin
          step(bit'($urandom_range(9) < 8),
               bit'($urandom_range(coin_div - 1) == 0),
               bit'($urandom_range(coin_div - 1) == 0));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
